// File: rtl/id_exe.sv
// ID/EXE pipeline register: captures decoded ID outputs, inserts bubbles on stall/flush,
// and feeds load-hazard info back to ID. Define ID_EXE_PERF_EN to add bubble/flush counters.
module id_exe #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h00000013
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_WIDTH-1:0]  inst_i,
    input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
    input  logic [RDATA_WIDTH-1:0] op1_i,
    input  logic [RDATA_WIDTH-1:0] op2_i,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   hold_i,
    input  logic                   bubble_i,
    input  logic                   flush_i,
    output logic [DATA_WIDTH-1:0]  inst_o,
    output logic [ADDR_WIDTH-1:0]  inst_addr_o,
    output logic [RDATA_WIDTH-1:0] op1_o,
    output logic [RDATA_WIDTH-1:0] op2_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   valid_o,
    output logic                   pre_inst_is_load_o,
    output logic [RADDR_WIDTH-1:0] exe_rd_o
`ifdef ID_EXE_PERF_EN
    ,
    output logic [31:0]            perf_bubble_cnt_o,
    output logic [31:0]            perf_flush_cnt_o
`endif
);

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    logic take_bubble;
    logic take_stall_bubble;
    logic capture;
    logic is_load;

    // Flush outranks hold so a wrong-path instruction is never retired.
    assign take_stall_bubble = !hold_i && bubble_i;
    assign take_bubble       = rst_i || flush_i || take_stall_bubble;
    assign capture           = !hold_i && !take_bubble;

    // Loads to x0 are excluded so ID never stalls on an rs = x0 compare.
    assign is_load = (inst_i[6:0] == OPC_LOAD) && reg_we_i && (reg_waddr_i != '0);

    always_ff @(posedge clk_i) begin
        if (take_bubble) begin
            inst_o             <= NOP_INST;
            inst_addr_o        <= '0;
            op1_o              <= '0;
            op2_o              <= '0;
            reg_we_o           <= 1'b0;
            reg_waddr_o        <= '0;
            valid_o            <= 1'b0;
            pre_inst_is_load_o <= 1'b0;
            exe_rd_o           <= '0;
        end else if (capture) begin
            inst_o             <= inst_i;
            inst_addr_o        <= inst_addr_i;
            op1_o              <= op1_i;
            op2_o              <= op2_i;
            reg_we_o           <= reg_we_i;
            reg_waddr_o        <= reg_waddr_i;
            valid_o            <= 1'b1;
            pre_inst_is_load_o <= is_load;
            exe_rd_o           <= reg_waddr_i;
        end
    end

`ifdef ID_EXE_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_bubble_cnt_o <= '0;
            perf_flush_cnt_o  <= '0;
        end else begin
            if (flush_i) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
            end
            if (take_stall_bubble && !flush_i) begin
                perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
